// File: rtl/cut_hash_extractor_if.sv
// AXI4-Stream bundle used on both the input and output side of the hash extractor.
interface cut_hash_extractor_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/cut_hash_extractor.sv
// Strips the trailing 16-byte hash from each packet, reporting it on hash_data,
// using a one-word holding register so a hash straddling two words can be trimmed.
module cut_hash_extractor #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int HASH_WIDTH           = 128
) (
  input  logic                        axi_aclk,
  input  logic                        axi_reset,
  input  logic                        strip_en,
  cut_hash_extractor_if.slave         s_axis,
  cut_hash_extractor_if.master        m_axis,
  output logic                        hash_valid,
  output logic [HASH_WIDTH-1:0]       hash_data,
  output logic [31:0]                 pkt_count,
  output logic [31:0]                 err_count
);

  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int MW = C_M_AXIS_DATA_WIDTH / 8;
  localparam logic [5:0]  HASH_BYTES = 6'(HASH_WIDTH / 8);
  localparam logic [5:0]  WORD_BYTES = 6'(SW);
  localparam logic [15:0] HASH_LEN   = 16'(HASH_WIDTH / 8);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] TAIL  = 2'd2;

  logic [1:0]                      state;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  h_data;
  logic [MW-1:0]                   h_strb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] h_user;
  logic                            strip_q;

  logic [5:0]            v;
  logic [8:0]            shamt;
  logic [HASH_WIDTH-1:0] hash_next;
  logic                  pkt_strip;
  logic                  short_last;
  logic                  s_ready;
  logic                  m_valid;
  logic                  m_last;
  logic [MW-1:0]         m_strb;
  logic [MW-1:0]         store_strb;
  logic                  accept;
  logic                  last_strip;
  logic                  runt;
  logic                  hash_fire;

  // Strobe with the top n byte lanes set; n may be 0..32.
  function automatic logic [MW-1:0] keep_mask(input logic [5:0] n);
    keep_mask = ~({MW{1'b1}} >> n);
  endfunction

  always_comb begin
    v = '0;
    for (int i = 0; i < SW; i++) v = v + 6'(s_axis.tstrb[i]);
  end

  // The hash always ends at byte V-1 of the last word, so one shift of the
  // concatenated held and incoming words covers both the straddled and unstraddled cases.
  assign shamt     = {WORD_BYTES - v, 3'b000};
  assign hash_next = HASH_WIDTH'({h_data, s_axis.tdata} >> shamt);

  always_comb begin
    pkt_strip  = (state == EMPTY) ? strip_en : strip_q;
    short_last = pkt_strip && s_axis.tlast && (v <= HASH_BYTES);
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    m_strb     = h_strb;
    case (state)
      EMPTY: s_ready = 1'b1;
      HOLD: begin
        s_ready = m_axis.tready;
        m_valid = s_axis.tvalid;
        m_last  = short_last;
        if (short_last) m_strb = keep_mask(v + HASH_BYTES);
      end
      TAIL: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
      end
      default: ;
    endcase
    if (axi_reset) begin
      s_ready = 1'b0;
      m_valid = 1'b0;
    end
  end

  assign accept     = s_axis.tvalid && s_ready;
  assign last_strip = accept && s_axis.tlast && pkt_strip;
  assign runt       = last_strip && (state == EMPTY) && (v <= HASH_BYTES);
  assign hash_fire  = last_strip && !runt;
  assign store_strb = (s_axis.tlast && pkt_strip) ? keep_mask(v - HASH_BYTES) : s_axis.tstrb;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tlast  = m_last;
  assign m_axis.tstrb  = m_strb;
  assign m_axis.tdata  = h_data;
  assign m_axis.tuser  = h_user;

  // The length field in tuser is corrected when the first word of a stripped
  // packet enters the holding register, so output never needs to know word position.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state      <= EMPTY;
      h_data     <= '0;
      h_strb     <= '0;
      h_user     <= '0;
      strip_q    <= 1'b0;
      hash_valid <= 1'b0;
      hash_data  <= '0;
      pkt_count  <= '0;
      err_count  <= '0;
    end else begin
      hash_valid <= hash_fire;
      if (hash_fire) begin
        hash_data <= hash_next;
        pkt_count <= pkt_count + 32'd1;
      end
      if (runt) err_count <= err_count + 32'd1;
      case (state)
        EMPTY: begin
          if (accept) begin
            strip_q <= strip_en;
            if (!runt) begin
              h_data <= s_axis.tdata;
              h_strb <= store_strb;
              h_user <= strip_en ?
                        {s_axis.tuser[C_S_AXIS_TUSER_WIDTH-1:16], s_axis.tuser[15:0] - HASH_LEN} :
                        s_axis.tuser;
              state  <= s_axis.tlast ? TAIL : HOLD;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            if (short_last) begin
              state <= EMPTY;
            end else begin
              h_data <= s_axis.tdata;
              h_strb <= store_strb;
              h_user <= s_axis.tuser;
              state  <= s_axis.tlast ? TAIL : HOLD;
            end
          end
        end
        TAIL: begin
          if (m_axis.tready) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/cut_hash_extractor.md
CUT_HASH_EXTRACTOR -- requirements
Module: cut_hash_extractor

Interface
REQ-001 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256: output stream data width.
REQ-002 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256: input stream data width.
REQ-003 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128: output tuser width.
REQ-004 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128: input tuser width.
REQ-005 SHALL have parameter HASH_WIDTH, default 128: width of the trailing hash; only the 256/128 data/hash combination is supported.
REQ-006 SHALL have one clock and a synchronous, active-high reset: axi_aclk input 1 (clock); axi_reset input 1 (synchronous, active-high).
REQ-007 SHALL have input slave stream ports: s_axis_tdata 256, s_axis_tstrb 32, s_axis_tuser 128, s_axis_tvalid 1, s_axis_tlast 1; s_axis_tready is an output 1.
REQ-008 SHALL have output master stream ports: m_axis_tdata 256, m_axis_tstrb 32, m_axis_tuser 128, m_axis_tvalid 1, m_axis_tlast 1; m_axis_tready is an input 1.
REQ-009 SHALL have strip_en input 1: 1 = strip the trailing hash, 0 = pass packets through unchanged.
REQ-010 SHALL have outputs hash_valid 1 and hash_data 128: a one-cycle pulse carrying the extracted hash.
REQ-011 SHALL have outputs pkt_count 32 (packets stripped) and err_count 32 (runt packets dropped).

Function
REQ-012 Byte order SHALL be MSB-first: byte 0 is tdata[255:248]; tstrb is contiguous from bit 31; V = number of set strobe bits in the last word (1..32).
REQ-013 The hash SHALL be the final 16 bytes of each input packet and may straddle the last two words.
REQ-014 strip_en SHALL be sampled on the first word of each packet and held for the whole packet.
REQ-015 SHALL implement states EMPTY, HOLD and TAIL, with one held word H of data, tstrb and tuser.
REQ-016 EMPTY behaviour:
- s_axis_tready=1 and m_axis_tvalid=0.
- Accepted non-last word is stored in H; next state HOLD.
- Accepted last word with strip_en=0, or with V>16: stored in H (strobe trimmed to V-16 bytes when stripping); next state TAIL.
- Accepted last word with strip_en=1 and V<=16 is a runt: dropped, err_count+1, no hash_valid, no output.
REQ-017 HOLD behaviour:
- m_axis_tvalid=s_axis_tvalid and s_axis_tready=m_axis_tready.
- On transfer, H is emitted and the input word is consumed.
- Input not last: H emitted with tlast=0; input stored in H; stay in HOLD.
- Input last, V>16 (or strip_en=0): H emitted with tlast=0; input stored in H (strobe trimmed to V-16 when stripping); next state TAIL.
- Input last, V<=16, stripping: H emitted with tlast=1 and strobe of 16+V bytes (all ones when V=16); input discarded; next state EMPTY.
REQ-018 TAIL behaviour: m_axis_tvalid=1, s_axis_tready=0, H emitted with tlast=1; on m_axis_tready, next state EMPTY.
REQ-019 Output tdata SHALL be H unmodified; bytes outside the strobe are don't-care.
REQ-020 On the first output word of a stripped packet, m_axis_tuser[15:0] SHALL be input tuser[15:0]-16; other tuser bits pass through unchanged, as do all tuser bits of passed-through packets.
REQ-021 hash_data SHALL be the 16 hash bytes in packet order, with the first hash byte at hash_data[127:120]:
- V>16: last-word bytes V-16..V-1.
- V=16: last-word bytes 0..15.
- V<16: H bytes 16+V..31, then last-word bytes 0..V-1.
REQ-022 hash_valid SHALL pulse for exactly one cycle, in the cycle the last input word is accepted, and pkt_count SHALL increment in that same cycle; neither applies to runts or to strip_en=0 packets.
REQ-023 Latency SHALL be one word: output word k is emitted no earlier than the cycle input word k+1 (or its tlast) is accepted; there are no bubbles under continuous valid and ready.
REQ-024 m_axis_tvalid SHALL never depend on m_axis_tready, and output data SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 Counters SHALL wrap modulo 2^32.

Reset
REQ-026 While axi_reset=1 at a clock edge:
- State returns to EMPTY and H is discarded.
- m_axis_tvalid=0, hash_valid=0, s_axis_tready=0.
- hash_data=0, pkt_count=0, err_count=0.
REQ-027 Reset asserted mid-packet SHALL drop the partial packet without emitting tlast; the first word accepted after reset is treated as a packet start.

Verification
REQ-028 Stripped packet: 3 words, last tstrb 32'hFFFF_FF00 (V=24), tuser len 88 -> 3 output words; last output tstrb 32'hFF00_0000, tlast=1; first tuser len 72; hash = last-word bytes 8..23; pkt_count=1.
REQ-029 Straddled hash: 2 words, last tstrb 32'hFFFC_0000 (V=14) -> 1 output word, tstrb 32'hFFFF_FFFC (30 bytes), tlast=1; hash = word0 bytes 30..31 followed by word1 bytes 0..13.
REQ-030 Runt: single word, tstrb 32'hFFFF_0000 (V=16), strip_en=1 -> no output, no hash_valid, err_count=1.
REQ-031 Pass-through: strip_en=0, 4-word packet -> 4 identical output words (data, strobe, tuser, tlast), no hash_valid, pkt_count unchanged.
REQ-032 Backpressure: m_axis_tready toggling 1/0 every cycle across back-to-back packets -> output stream identical to the ready=1 run, with no words lost or duplicated.
REQ-033 Reset mid-packet: reset after word 2 of a 5-word packet, then a clean 2-word packet -> only the clean packet is output; counters reflect only the clean packet.
